// File: rtl/gups_sys.sv
// GUPS-style random-access update engine: xoshiro256+ picks a masked word
// address, the word is read over a req/rdy port, incremented and written back.
module gups_sys #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] addr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         req,
  output logic         wr,
  input  logic         rdy,
  input  logic [W-1:0] seed0,
  input  logic [W-1:0] seed1,
  input  logic [W-1:0] seed2,
  input  logic [W-1:0] seed3,
  input  logic [W-1:0] range
);

  typedef enum logic [2:0] {
    ST_GEN = 3'd0,
    ST_RD  = 3'd1,
    ST_RDW = 3'd2,
    ST_INC = 3'd3,
    ST_WR  = 3'd4,
    ST_WRW = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] dout_q, dout_d;
  logic [W-1:0] cap_q, cap_d;
  logic         req_q, req_d;
  logic         wr_q, wr_d;

  logic [W-1:0] seed0_eff_s;
  logic [W-1:0] rnd_s, t_s, x2_s, x3_s;
  logic [W-1:0] n0_s, n1_s, n2_s, n3_s;

  // An all-zero state would lock the generator at zero forever.
  assign seed0_eff_s = ((seed0 | seed1 | seed2 | seed3) == {W{1'b0}})
                       ? {{(W-1){1'b0}}, 1'b1} : seed0;

  // One xoshiro256+ step; the partial results chain in the algorithm's order.
  assign rnd_s = s0_q + s3_q;
  assign t_s   = s1_q << 17;
  assign x2_s  = s2_q ^ s0_q;
  assign x3_s  = s3_q ^ s1_q;
  assign n1_s  = s1_q ^ x2_s;
  assign n0_s  = s0_q ^ x3_s;
  assign n2_s  = x2_s ^ t_s;
  assign n3_s  = (x3_s << 45) | (x3_s >> (W - 45));

  // Next-state and output-register logic for the update sequence.
  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    cap_d   = cap_q;
    req_d   = req_q;
    wr_d    = wr_q;
    case (state_q)
      ST_GEN: begin
        addr_d  = rnd_s & range;
        s0_d    = n0_s;
        s1_d    = n1_s;
        s2_d    = n2_s;
        s3_d    = n3_s;
        req_d   = 1'b0;
        state_d = ST_RD;
      end
      ST_RD: begin
        req_d   = 1'b1;
        wr_d    = 1'b0;
        state_d = ST_RDW;
      end
      ST_RDW: begin
        if (rdy) begin
          cap_d   = din;
          req_d   = 1'b0;
          state_d = ST_INC;
        end else begin
          state_d = ST_RDW;
        end
      end
      ST_INC: begin
        dout_d  = cap_q + {{(W-1){1'b0}}, 1'b1};
        req_d   = 1'b0;
        state_d = ST_WR;
      end
      ST_WR: begin
        req_d   = 1'b1;
        wr_d    = 1'b1;
        state_d = ST_WRW;
      end
      ST_WRW: begin
        if (rdy) begin
          req_d   = 1'b0;
          state_d = ST_GEN;
        end else begin
          state_d = ST_WRW;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_GEN;
      end
    endcase
  end

  // State, generator and output registers; reset overrides any pending rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_GEN;
      s0_q    <= seed0_eff_s;
      s1_q    <= seed1;
      s2_q    <= seed2;
      s3_q    <= seed3;
      addr_q  <= {W{1'b0}};
      dout_q  <= {W{1'b0}};
      cap_q   <= {W{1'b0}};
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      cap_q   <= cap_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
    end
  end

  assign addr = addr_q;
  assign dout = dout_q;
  assign req  = req_q;
  assign wr   = wr_q;

endmodule

// File: tb/tb_gups_sys.sv
// Bench for gups_sys: table of update vectors, reset/boundary sequences and a
// randomized memory model with a scoreboard of expected write data.
module tb_gups_sys;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] addr, dout;
  logic [63:0] din = 64'h0;
  logic        req, wr;
  logic        rdy = 1'b0;
  logic [63:0] seed0 = 64'h1, seed1 = 64'h2, seed2 = 64'h3, seed3 = 64'h4;
  logic [63:0] range_i = 64'hff;

  gups_sys #(.W(64)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
    .req(req), .wr(wr), .rdy(rdy),
    .seed0(seed0), .seed1(seed1), .seed2(seed2), .seed3(seed3),
    .range(range_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] din_v;
    int          rd_dly;
    int          wr_dly;
    logic [63:0] exp_dout;
    bit          stray;
  } vec_t;

  vec_t        vecs [6];
  int          checks = 0;
  int          errors = 0;
  int          low_cnt = 0;
  logic [63:0] sb_q [$];
  logic [63:0] m0, m1, m2, m3;
  logic [63:0] mem [0:8191];
  logic [63:0] cnt [0:255];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_init();
    m0 = seed0; m1 = seed1; m2 = seed2; m3 = seed3;
    if ((m0 | m1 | m2 | m3) == 64'h0) m0 = 64'h1;
  endtask

  // Reference xoshiro256+ step producing the next expected address.
  task automatic model_step(output logic [63:0] a);
    logic [63:0] r, t;
    r = m0 + m3;
    t = m1 << 17;
    m2 = m2 ^ m0;
    m3 = m3 ^ m1;
    m1 = m1 ^ m2;
    m0 = m0 ^ m3;
    m2 = m2 ^ t;
    m3 = {m3[18:0], m3[63:19]};
    a = r & range_i;
  endtask

  task automatic apply_reset(input logic [63:0] s0, input logic [63:0] s1,
                             input logic [63:0] s2, input logic [63:0] s3,
                             input logic [63:0] rng, input logic with_rdy);
    seed0 = s0; seed1 = s1; seed2 = s2; seed3 = s3; range_i = rng;
    rst = 1'b1;
    rdy = with_rdy;
    @(negedge clk);
    rdy = 1'b0;
    chk("rst_req", 64'(req), 64'h0);
    chk("rst_wr", 64'(wr), 64'h0);
    chk("rst_addr", addr, 64'h0);
    chk("rst_dout", dout, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    model_init();
    sb_q.delete();
    low_cnt = 0;
  endtask

  task automatic wait_req(input logic exp_wr);
    int n = 0;
    while (req !== 1'b1 && n < 64) begin
      low_cnt++;
      n++;
      @(negedge clk);
    end
    if (req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got req=%b expected 1 within 64 cycles", req);
    end else begin
      chk("req_gap", 64'(low_cnt >= 2), 64'h1);
      chk("req_wr", 64'(wr), 64'(exp_wr));
    end
    low_cnt = 0;
  endtask

  task automatic hold_and_ack(input int dly, input logic [63:0] din_v, input bit stray);
    logic [63:0] a0, d0;
    logic        w0;
    a0 = addr; d0 = dout; w0 = wr;
    for (int i = 1; i < dly; i++) begin
      @(negedge clk);
      chk("hold_req", 64'(req), 64'h1);
      chk("hold_addr", addr, a0);
      chk("hold_wr", 64'(wr), 64'(w0));
      chk("hold_dout", dout, d0);
    end
    rdy = 1'b1;
    din = din_v;
    @(negedge clk);
    rdy = 1'b0;
    chk("req_drop", 64'(req), 64'h0);
    if (stray) begin
      rdy = 1'b1;
      low_cnt = 1;
      @(negedge clk);
      rdy = 1'b0;
    end
  endtask

  task automatic do_read(input logic [63:0] din_v, input int dly, input logic [63:0] exp_addr,
                         input logic [63:0] exp_dout, input bit stray, output logic [63:0] a_obs);
    wait_req(1'b0);
    a_obs = addr;
    chk("rd_addr", addr, exp_addr);
    sb_q.push_back(exp_dout);
    hold_and_ack(dly, din_v, stray);
  endtask

  task automatic do_write(input int dly, input logic [63:0] a_rd, input bit stray);
    logic [63:0] e;
    wait_req(1'b1);
    chk("wr_addr", addr, a_rd);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL wr_dout: got %h expected nothing (scoreboard empty)", dout);
    end else begin
      e = sb_q.pop_front();
      chk("wr_dout", dout, e);
    end
    hold_and_ack(dly, 64'h0, stray);
  endtask

  initial begin
    logic [63:0] ea, a;
    int          rd_d, wr_d;

    vecs[0] = '{64'h10, 2, 2, 64'h11, 1'b0};
    vecs[1] = '{64'hffff_ffff_ffff_ffff, 1, 1, 64'h0, 1'b0};
    vecs[2] = '{64'h0, 10, 10, 64'h1, 1'b0};
    vecs[3] = '{64'h7fff_ffff_ffff_ffff, 3, 1, 64'h8000_0000_0000_0000, 1'b1};
    vecs[4] = '{64'hdead_beef, 1, 8, 64'hdead_bef0, 1'b1};
    vecs[5] = '{64'hffff_ffff_0000_0000, 5, 2, 64'hffff_ffff_0000_0001, 1'b0};

    apply_reset(64'h1, 64'h2, 64'h3, 64'h4, 64'hff, 1'b0);
    for (int i = 0; i < 6; i++) begin
      model_step(ea);
      do_read(vecs[i].din_v, vecs[i].rd_dly, ea, vecs[i].exp_dout, vecs[i].stray, a);
      if (i == 0) chk("first_addr", a, 64'h5);
      if (i == 1) chk("second_addr", a, 64'h7);
      do_write(vecs[i].wr_dly, a, vecs[i].stray);
    end

    // Reset while waiting on a read, with a coincident rdy.
    wait_req(1'b0);
    apply_reset(64'h1, 64'h2, 64'h3, 64'h4, 64'hff, 1'b1);
    model_step(ea);
    do_read(64'h40, 2, ea, 64'h41, 1'b0, a);
    chk("addr_after_rdw_rst", a, 64'h5);
    do_write(1, a, 1'b0);

    // Reset while waiting on a write.
    wait_req(1'b0);
    apply_reset(64'h1, 64'h2, 64'h3, 64'h4, 64'hff, 1'b1);
    model_step(ea);
    do_read(64'h40, 2, ea, 64'h41, 1'b0, a);
    wait_req(1'b1);
    apply_reset(64'h1, 64'h2, 64'h3, 64'h4, 64'hff, 1'b1);
    model_step(ea);
    do_read(64'h7, 1, ea, 64'h8, 1'b0, a);
    chk("addr_after_wrw_rst", a, 64'h5);
    do_write(1, a, 1'b0);

    // range = 0 forces every address to 0.
    apply_reset(64'h1, 64'h2, 64'h3, 64'h4, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      model_step(ea);
      do_read(64'(i), 1, ea, 64'(i + 1), 1'b0, a);
      chk("range0_addr", a, 64'h0);
      do_write(1, a, 1'b0);
    end

    // range = all-ones passes the full random value.
    apply_reset(64'h1, 64'h2, 64'h3, 64'h4, 64'hffff_ffff_ffff_ffff, 1'b0);
    model_step(ea);
    do_read(64'h5, 1, ea, 64'h6, 1'b0, a);
    chk("full_addr0", a, 64'h5);
    do_write(1, a, 1'b0);
    model_step(ea);
    do_read(64'h5, 1, ea, 64'h6, 1'b0, a);
    chk("full_addr1", a, 64'h0000_c000_0000_0007);
    do_write(1, a, 1'b0);

    // All-zero seeds substitute s0 = 1.
    apply_reset(64'h0, 64'h0, 64'h0, 64'h0, 64'hff, 1'b0);
    model_step(ea);
    do_read(64'h0, 1, ea, 64'h1, 1'b0, a);
    chk("zero_seed_addr", a, 64'h1);
    do_write(1, a, 1'b0);

    // Randomized run against a memory model and per-address counters.
    for (int i = 0; i < 8192; i++) mem[i] = 64'h0;
    for (int i = 0; i < 256; i++) cnt[i] = 64'h0;
    apply_reset(64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                64'h0f1e_2d3c_4b5a_6978, 64'h8796_a5b4_c3d2_e1f0, 64'hff, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      model_step(ea);
      rd_d = int'($urandom_range(8, 1));
      wr_d = int'($urandom_range(8, 1));
      do_read(mem[ea[12:0]], rd_d, ea, cnt[ea[7:0]] + 64'h1, 1'b0, a);
      chk("rand_addr_bound", 64'(a <= 64'hff), 64'h1);
      do_write(wr_d, a, 1'b0);
      cnt[ea[7:0]] = cnt[ea[7:0]] + 64'h1;
      mem[ea[12:0]] = cnt[ea[7:0]];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
